// File: rtl/mdu_pkg.sv
// Shared MDU op codes and default latencies.
// Used by the control unit decoder and by e_mdu.
package mdu_pkg;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO registers.
// Multi-cycle ops hold busy for a fixed count, then commit HI/LO.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUop,
    input  logic        start,
    input  logic [31:0] E_MDU_A,
    input  logic [31:0] E_MDU_B,
    output logic        busy,
    output logic [31:0] E_MDU_out,
    output logic [31:0] HI_q,
    output logic [31:0] LO_q
);

    localparam int MAX_C =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_C) + 1;

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       hi_d, lo_d;

    logic [31:0]       res_hi, res_lo;
    logic              res_wr;

    logic signed [63:0] a_sx, b_sx;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        dvs;
    logic [31:0]        mag_a, mag_b;
    logic [31:0]        q_mag, r_mag;
    logic [31:0]        q_s, r_s;
    logic [31:0]        q_u, r_u;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            HI_q    <= '0;
            LO_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            HI_q    <= hi_d;
            LO_q    <= lo_d;
        end
    end

    // Arithmetic on latched operands only
    assign a_sx   = {{32{a_q[31]}}, a_q};
    assign b_sx   = {{32{b_q[31]}}, b_q};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Divisor forced nonzero; a zero divide never commits anyway
    assign dvs   = (b_q == 32'd0) ? 32'd1 : b_q;
    assign mag_a = a_q[31] ? (32'd0 - a_q) : a_q;
    assign mag_b = dvs[31] ? (32'd0 - dvs) : dvs;
    assign q_mag = mag_a / mag_b;
    assign r_mag = mag_a % mag_b;
    assign q_s   = (a_q[31] ^ dvs[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s   = a_q[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u   = a_q / dvs;
    assign r_u   = a_q % dvs;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b0;
        unique case (1'b1)
            (op_q == MDU_MULT): begin
                {res_hi, res_lo} = prod_s;
                res_wr = 1'b1;
            end
            (op_q == MDU_MULTU): begin
                {res_hi, res_lo} = prod_u;
                res_wr = 1'b1;
            end
            (op_q == MDU_DIV): begin
                res_hi = r_s;
                res_lo = q_s;
                res_wr = (b_q != 32'd0);
            end
            (op_q == MDU_DIVU): begin
                res_hi = r_u;
                res_lo = q_u;
                res_wr = (b_q != 32'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = HI_q;
        lo_d    = LO_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && is_long_op(E_MDUop)) begin
                    op_d    = E_MDUop;
                    a_d     = E_MDU_A;
                    b_d     = E_MDU_B;
                    cnt_d   = is_mult_op(E_MDUop) ?
                              CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_d = ST_RUN;
                end else if (E_MDUop == MDU_MTHI) begin
                    hi_d = E_MDU_A;
                end else if (E_MDUop == MDU_MTLO) begin
                    lo_d = E_MDU_A;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN);

    always_comb begin
        E_MDU_out = '0;
        unique case (1'b1)
            (E_MDUop == MDU_MFHI): E_MDU_out = HI_q;
            (E_MDUop == MDU_MFLO): E_MDU_out = LO_q;
            default: ;
        endcase
    end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy-cycle count for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy-cycle count for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port E_MDUop  input  4  operation code for the E-stage instruction.
REQ-006 SHALL have port start  input  1  one-cycle launch strobe for mult/multu/div/divu.
REQ-007 SHALL have port E_MDU_A  input  32  forwarded rs value.
REQ-008 SHALL have port E_MDU_B  input  32  forwarded rt value.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight.
REQ-010 SHALL have port E_MDU_out  output  32  mfhi/mflo read data for E_RegWD selection.
REQ-011 SHALL have port HI_q  output  32  architectural HI register.
REQ-012 SHALL have port LO_q  output  32  architectural LO register.

Function
REQ-013 SHALL decode E_MDUop as follows: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; codes 9-15 act as none.
REQ-014 SHALL use a two-state FSM, IDLE and RUN, plus a down-counter of width clog2(max(MULT_CYCLES,DIV_CYCLES))+1.
REQ-015 In IDLE, start=1 with op 1-4 SHALL do the following at the edge: latch the operands and op, load the counter with MULT_CYCLES or DIV_CYCLES, and go to RUN.
REQ-016 SHALL hold busy=1 in RUN, with busy high for exactly N consecutive cycles starting the cycle after start.
REQ-017 In RUN, the counter SHALL decrement each edge; at the edge where it reaches 0, HI/LO SHALL be written and the FSM SHALL return to IDLE, so new HI/LO are visible the first cycle busy=0.
REQ-018 mult/multu SHALL produce a 64-bit product, signed or unsigned respectively, with HI=[63:32] and LO=[31:0].
REQ-019 div/divu SHALL produce LO=quotient (truncated toward zero) and HI=remainder (sign of the dividend); divu is unsigned.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-021 Divide with E_MDU_B=0 SHALL still occupy DIV_CYCLES cycles, but HI/LO SHALL remain unchanged.
REQ-022 start while in RUN SHALL be ignored; start with op not in 1-4 SHALL be ignored.
REQ-023 mthi/mtlo in IDLE SHALL write E_MDU_A to HI/LO at the edge, with no busy; in RUN they SHALL be ignored.
REQ-024 E_MDU_out SHALL be combinational: HI_q for mfhi, LO_q for mflo, otherwise 0; it reflects current register values with no latency.
REQ-025 The stall unit SHALL stall any D-stage MDU instruction when (busy | start); e_mdu SHALL assume it never receives overlapping starts under correct stalling.
REQ-026 Operand latching SHALL make results independent of E_MDU_A/B changes during RUN.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, counter=0, busy=0, HI_q=0, and LO_q=0, including mid-operation; the in-flight result SHALL be discarded.
REQ-028 After reset release, the first start SHALL behave per REQ-015 with no residual state.

Structure
REQ-029 Op codes 0-8 and the default cycle counts SHALL be defined in the shared package mdu_pkg and used by both CU and e_mdu.
REQ-030 No sub-module is required; arithmetic SHALL be inline combinational logic on the latched operands, computed in RUN.
REQ-031 mips SHALL instantiate e_mdu in stage E and SHALL extend the E/M RegWD mux with E_MDU_out.

Verification
REQ-032 Scenario mult: A=0xFFFFFFFD, B=5, start -> busy 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFF1.
REQ-033 Scenario divu then div: divu 7/2 -> 10 busy cycles, LO=3, HI=1; then div 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 Scenario divide by zero: mtlo 0x1234, mthi 0x5678, then div A=9, B=0 -> 10 busy cycles, then LO=0x1234, HI=0x5678, and mflo output=0x1234.
REQ-035 Scenario overflow and ignored start: div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; a second start at busy cycle 3 leaves the total busy count at 10 and the result unchanged.
REQ-036 Scenario reset mid-op: multu 0xFFFFFFFF*2, assert reset at busy cycle 2 -> busy=0 and HI/LO=0 immediately (asynchronously); after release, mflo output=0.
